// File: rtl/fir_tap_filter_p.sv
// Pipelined N-tap FIR filter for unsigned samples: run-time coefficient RAM,
// valid-qualified tap line, fixed 2-stage output latency, right-shift scaling with saturation.
module fir_tap_filter_p #(
    parameter int DATA_W   = 8,
    parameter int NUM_TAPS = 4,
    parameter int COEF_W   = 8,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 0,
    parameter int COEF_RST = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]           coef_wdata,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    output logic                        out_valid,
    output logic [OUT_W-1:0]            out_data,
    output logic                        out_sat
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(NUM_TAPS);
    localparam int CMP_W  = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    logic [DATA_W-1:0] tap      [NUM_TAPS];
    logic [COEF_W-1:0] coef     [NUM_TAPS];
    logic [COEF_W-1:0] coef_lat [NUM_TAPS];
    logic [PROD_W-1:0] prod     [NUM_TAPS];
    logic              tap_valid;
    logic              prod_valid;

    logic [ACC_W-1:0]  sum;
    logic [CMP_W-1:0]  scaled;
    logic              clip;

    // NOTE: the coefficient RAM is reset explicitly because the filter must restart from a
    // known response; pure storage with no such requirement would be left unreset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef[k] <= COEF_W'(COEF_RST);
            end
        end else if (coef_we) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (int'(coef_addr) == k) begin
                    coef[k] <= coef_wdata;
                end
            end
        end
    end

    // Coefficients are captured alongside the sample, so a write on the same edge is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tap_valid <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                tap[k]      <= '0;
                coef_lat[k] <= '0;
            end
        end else begin
            tap_valid <= in_valid;
            if (in_valid) begin
                tap[0] <= in_data;
                for (int k = 1; k < NUM_TAPS; k++) begin
                    tap[k] <= tap[k-1];
                end
                for (int k = 0; k < NUM_TAPS; k++) begin
                    coef_lat[k] <= coef[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_valid <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod[k] <= '0;
            end
        end else begin
            prod_valid <= tap_valid;
            if (tap_valid) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    prod[k] <= PROD_W'(tap[k]) * PROD_W'(coef_lat[k]);
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned
    // (which would infer a latch); the running sum uses blocking '=' so each iteration sees
    // the previous partial sum, unlike the '<=' used for registers.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            sum = sum + ACC_W'(prod[k]);
        end
        scaled = CMP_W'(sum >> SHIFT);
        clip   = (scaled > CMP_W'({OUT_W{1'b1}}));
    end

    // Output registers only load on a valid result, so they hold between pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= prod_valid;
            if (prod_valid) begin
                out_data <= clip ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
                out_sat  <= clip;
            end
        end
    end
endmodule

// File: tb/tb_fir_tap_filter_p.sv
// Directed bench for fir_tap_filter_p: default instance plus a SHIFT=3 instance on shared
// stimulus, a vector table for reset/impulse/gaps/saturation, and hand sequences for the rest.
module tb_fir_tap_filter_p;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       coef_we;
    logic [1:0] coef_addr;
    logic [7:0] coef_wdata;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_valid_a, out_sat_a;
    logic [7:0] out_data_a;
    logic       out_valid_b, out_sat_b;
    logic [7:0] out_data_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fir_tap_filter_p dut_a (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_sat(out_sat_a)
    );

    fir_tap_filter_p #(.SHIFT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_wdata(coef_wdata), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_sat(out_sat_b)
    );

    // Inputs for one edge, and the outputs expected right after that edge.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ea;
        logic       sa;
        logic [7:0] eb;
        logic       sb;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic ev,
                                input logic [7:0] ea, input logic sa,
                                input logic [7:0] eb, input logic sb);
        vec_t r;
        r.v = v; r.d = d; r.ev = ev; r.ea = ea; r.sa = sa; r.eb = eb; r.sb = sb;
        vecs.push_back(r);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [7:0] ea,
                             input logic sa, input logic [7:0] eb, input logic sb);
        check({tag, " valid_a"}, 32'(out_valid_a), 32'(ev));
        check({tag, " data_a"},  32'(out_data_a),  32'(ea));
        check({tag, " sat_a"},   32'(out_sat_a),   32'(sa));
        check({tag, " valid_b"}, 32'(out_valid_b), 32'(ev));
        check({tag, " data_b"},  32'(out_data_b),  32'(eb));
        check({tag, " sat_b"},   32'(out_sat_b),   32'(sb));
    endtask

    // Drive inputs away from the edge, then sample 1 ns after it.
    task automatic cycle(input logic v, input logic [7:0] d, input logic we,
                         input logic [1:0] a, input logic [7:0] w);
        @(negedge clk);
        in_valid = v; in_data = d; coef_we = we; coef_addr = a; coef_wdata = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset and impulse (coef = 2 everywhere; B output is S >> 3).
        add(1, 0,   0, 0, 0, 0, 0);
        add(0, 0,   0, 0, 0, 0, 0);
        add(1, 10,  1, 0, 0, 0, 0);
        add(1, 0,   0, 0, 0, 0, 0);
        add(1, 0,   1, 20, 0, 2, 0);
        add(1, 0,   1, 20, 0, 2, 0);
        add(1, 0,   1, 20, 0, 2, 0);
        add(0, 0,   1, 20, 0, 2, 0);
        add(0, 0,   1, 0, 0, 0, 0);
        // Same impulse with three idle cycles between samples.
        add(1, 10,  0, 0, 0, 0, 0);
        add(0, 0,   0, 0, 0, 0, 0);
        add(0, 0,   1, 20, 0, 2, 0);
        add(0, 0,   0, 20, 0, 2, 0);
        for (int i = 0; i < 3; i++) begin
            add(1, 0, 0, 20, 0, 2, 0);
            add(0, 0, 0, 20, 0, 2, 0);
            add(0, 0, 1, 20, 0, 2, 0);
            add(0, 0, 0, 20, 0, 2, 0);
        end
        add(1, 0,   0, 20, 0, 2, 0);
        add(0, 0,   0, 20, 0, 2, 0);
        add(0, 0,   1, 0, 0, 0, 0);
        add(0, 0,   0, 0, 0, 0, 0);
        // Saturation: S = 510, 1020, 1530, 2040.
        add(1, 255, 0, 0, 0, 0, 0);
        add(1, 255, 0, 0, 0, 0, 0);
        add(1, 255, 1, 255, 1, 63, 0);
        add(1, 255, 1, 255, 1, 127, 0);
        add(0, 0,   1, 255, 1, 191, 0);
        add(0, 0,   1, 255, 1, 255, 0);
        add(0, 0,   0, 255, 1, 255, 0);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_out("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].v, vecs[i].d, 0, 0, 0);
            check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ea, vecs[i].sa,
                      vecs[i].eb, vecs[i].sb);
        end

        // Coefficient write on the same edge as sample m: m sees coef 2, m+1 sees coef 7.
        for (int i = 0; i < 4; i++) cycle(1, 5, 0, 0, 0);
        cycle(1, 5, 1, 0, 7);
        cycle(1, 5, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_out("coef_old", 1, 40, 0, 5, 0);
        cycle(0, 0, 0, 0, 0);
        check_out("coef_new", 1, 65, 0, 8, 0);
        cycle(0, 0, 0, 0, 0);
        check_out("coef_idle", 0, 65, 0, 8, 0);

        // Reset with two samples in flight: neither may emerge.
        cycle(1, 9, 0, 0, 0);
        cycle(1, 9, 0, 0, 0);
        rst_n = 1'b0;
        cycle(0, 0, 0, 0, 0);
        check_out("rst_mid0", 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_out("rst_mid1", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0);
        check_out("rst_rel", 0, 0, 0, 0, 0);
        cycle(1, 3, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_out("rst_lat1", 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check_out("rst_first", 1, 6, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
